// File: rtl/carry_resolve_stage.sv
// carry_resolve_stage: second stage of the modulo-(2^WIDTH - 1) adder/subtractor.
// Captures the dual-rail half-sum (a) and shifted half-carry (b) vectors, then
// resolves carries one carry-save step per clock with end-around carry. It
// returns a normalized residue through a valid/ready handshake.
// Optional feature macro: CARRY_RESOLVE_RAIL_CHECK_EN (dual-rail integrity check).
module carry_resolve_stage #(
  parameter int WIDTH    = 4,
  parameter int MAX_ITER = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_0,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] b_0,
  input  logic [WIDTH-1:0] b_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] c_reg;
  logic [CNT_W-1:0] cnt;

  // A left rotation by one is multiplication by 2 modulo 2^WIDTH - 1.
  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // All-ones is the ones'-complement negative zero and is reported as 0.
  function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] v);
    return (&v) ? '0 : v;
  endfunction

  logic             rail_bad;
  logic [WIDTH-1:0] c_cap;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] c_nxt;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef CARRY_RESOLVE_RAIL_CHECK_EN
  // Any rail pair that is not complementary (00 or 11) is a violation.
  assign rail_bad = (|(~(a_0 ^ a_1))) | (|(~(b_0 ^ b_1)));
`else
  // The complement rails carry no information when the check is disabled.
  assign rail_bad = 1'b0;
  wire unused_rails = &{1'b0, a_1, b_1};
`endif

  // b arrives with bit k-1 holding weight 2^k; the top bit wraps to weight 1.
  assign c_cap   = rotl1(b_0);
  assign a_nxt   = a_reg ^ c_reg;
  assign c_nxt   = rotl1(a_reg & c_reg);
  assign cnt_nxt = cnt + CNT_W'(1);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Capture, iterative carry resolution and result hold, with async reset.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values of a_reg/c_reg/cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      c_reg  <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_0;
            c_reg <= c_cap;
            cnt   <= '0;
            if (rail_bad) begin
              state  <= DONE;
              result <= '0;
              err    <= 1'b1;
            end else if (c_cap == '0) begin
              state  <= DONE;
              result <= norm(a_0);
              err    <= 1'b0;
            end else begin
              state  <= ITER;
            end
          end
        end
        ITER: begin
          a_reg <= a_nxt;
          c_reg <= c_nxt;
          cnt   <= cnt_nxt;
          if (c_nxt == '0) begin
            state  <= DONE;
            result <= norm(a_nxt);
            err    <= 1'b0;
          end else if (cnt_nxt == CNT_W'(MAX_ITER)) begin
            state  <= DONE;
            result <= '0;
            err    <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_resolve_stage.sv
// Self-checking bench for carry_resolve_stage: directed vector table, corner
// sequences (backpressure, mid-operation reset, timeout) and random operands
// checked against an arithmetic residue model.
module tb_carry_resolve_stage;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] a_0, a_1, b_0, b_1, result;

  // Second instance with a short iteration limit for the timeout case.
  logic         t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_err;
  logic [W-1:0] t_a_0, t_a_1, t_b_0, t_b_1, t_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  carry_resolve_stage #(.WIDTH(W), .MAX_ITER(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  carry_resolve_stage #(.WIDTH(W), .MAX_ITER(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .a_0(t_a_0), .a_1(t_a_1), .b_0(t_b_0), .b_1(t_b_1),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .result(t_result), .err(t_err)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a0, a1, b0, b1;
    int           k;
    logic [W-1:0] res;
    logic         e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Residue model: b_0 bit k-1 has weight 2^k, so the sum is a + 2*b mod 15,
  // and the normalized residue never shows the all-ones form.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int m;
    m = (1 << W) - 1;
    return W'((int'(a) + 2 * int'(b)) % m);
  endfunction

  // Present one operand and wait (bounded) for out_valid; returns update count.
  task automatic run_op(input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] b0, input logic [W-1:0] b1,
                        output int lat, output bit done);
    a_0 = a0; a_1 = a1; b_0 = b0; b_1 = b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    done = out_valid;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_ov_drop"}, out_valid, 0);
    check({name, "_ir_rise"}, in_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    int           lat;
    bit           done;
    logic [W-1:0] hold_res;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; in_valid = 0; out_ready = 0;
    a_0 = '0; a_1 = '0; b_0 = '0; b_1 = '0;
    t_in_valid = 0; t_out_ready = 0;
    t_a_0 = '0; t_a_1 = '0; t_b_0 = '0; t_b_1 = '0;

    vecs.push_back('{"add_5p3",   4'b0110, 4'b1001, 4'b0001, 4'b1110, 3, 4'b1000, 1'b0});
    vecs.push_back('{"sub_5m3",   4'b1001, 4'b0110, 4'b0100, 4'b1011, 3, 4'b0010, 1'b0});
    vecs.push_back('{"neg_zero",  4'b1111, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0000, 1'b0});
    vecs.push_back('{"chain",     4'b1111, 4'b0000, 4'b1000, 4'b0111, 5, 4'b0001, 1'b0});
    vecs.push_back('{"zero",      4'b0000, 4'b1111, 4'b0000, 4'b1111, 0, 4'b0000, 1'b0});
`ifdef CARRY_RESOLVE_RAIL_CHECK_EN
    vecs.push_back('{"rail_a",    4'b0110, 4'b1101, 4'b0001, 4'b1110, 0, 4'b0000, 1'b1});
    vecs.push_back('{"rail_b",    4'b0110, 4'b1001, 4'b0001, 4'b1111, 0, 4'b0000, 1'b1});
`else
    vecs.push_back('{"rail_a",    4'b0110, 4'b1101, 4'b0001, 4'b1110, 3, 4'b1000, 1'b0});
    vecs.push_back('{"rail_b",    4'b0110, 4'b1001, 4'b0001, 4'b1111, 3, 4'b1000, 1'b0});
`endif

    #12;
    // Reset state while rst_n is held low.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      check({vecs[i].name, "_in_ready"}, in_ready, 1);
      run_op(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, lat, done);
      check({vecs[i].name, "_done"}, done, 1);
      check({vecs[i].name, "_latency"}, lat, vecs[i].k);
      check({vecs[i].name, "_result"}, result, vecs[i].res);
      check({vecs[i].name, "_err"}, err, vecs[i].e);
      if (done) handshake(vecs[i].name);
    end

    // Backpressure: hold out_ready low and offer a competing operand.
    run_op(4'b0110, 4'b1001, 4'b0001, 4'b1110, lat, done);
    hold_res = result;
    check("bp_result", hold_res, 4'b1000);
    a_0 = 4'b0011; a_1 = 4'b1100; b_0 = 4'b0101; b_1 = 4'b1010;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result_hold", result, hold_res);
      check("bp_err_hold", err, 0);
    end
    in_valid = 1'b0;
    handshake("bp");

    // Reset during ITER: outputs return to reset values at once.
    a_0 = 4'b1111; a_1 = 4'b0000; b_0 = 4'b1000; b_1 = 4'b0111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'b1001, 4'b0110, 4'b0100, 4'b1011, lat, done);
    check("postrst_done", done, 1);
    check("postrst_result", result, 4'b0010);
    if (done) handshake("postrst");

    // Timeout with MAX_ITER = 4 on the 5-update chain.
    t_a_0 = 4'b1111; t_a_1 = 4'b0000; t_b_0 = 4'b1000; t_b_1 = 4'b0111;
    t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    lat = 0;
    while (!t_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("tmo_done", t_out_valid, 1);
    check("tmo_latency", lat, 4);
    check("tmo_err", t_err, 1);
    check("tmo_result", t_result, 0);
    t_out_ready = 1'b1;
    @(posedge clk); #1;
    t_out_ready = 1'b0;
    check("tmo_in_ready", t_in_ready, 1);

    // Random operands with complementary rails against the residue model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, ~ra, rb, ~rb, lat, done);
      check("rnd_done", done, 1);
      check("rnd_result", result, model(ra, rb));
      check("rnd_err", err, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (done) handshake("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
